// File: rtl/ifu.sv
// ifu: instruction fetch unit. Issues word fetches, holds the fetched instruction until accepted, and redirects on jump/branch.
// Optional build macro IFU_PREFETCH_EN adds a one-entry sequential prefetch buffer filled while an instruction is held.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, DROP = 2'd3} state_t;

  state_t      state_r, state_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] ins_r, ins_s;
  logic [31:0] ins_pc_r, ins_pc_s;
  logic        req_r, req_s;
  logic        valid_r, valid_s;
  logic        accept_s, redirect_s;
  logic [31:0] seq_pc_s, target_s;
`ifdef IFU_PREFETCH_EN
  logic [31:0] buf_r, buf_s;
  logic [31:0] tgt_r, tgt_s;
  logic        buf_valid_r, buf_valid_s;
`endif

  // Jump keeps the top nibble of the sequential pc; branch offset is a signed word count.
  function automatic logic [31:0] redirect_target(input logic [31:0] seq_pc,
                                                  input logic [31:0] word,
                                                  input logic        jump);
    logic [31:0] br_off;
    br_off = {{14{word[15]}}, word[15:0], 2'b00};
    if (jump) begin
      return {seq_pc[31:28], word[25:0], 2'b00};
    end else begin
      return seq_pc + br_off;
    end
  endfunction

  assign imem_req  = req_r;
  assign imem_addr = addr_r;
  assign ins       = ins_r;
  assign ins_pc    = ins_pc_r;
  assign ins_valid = valid_r;

  // Decode the accept handshake and the redirect target of the held instruction.
  always_comb begin
    accept_s   = valid_r & ins_ready;
    redirect_s = Jump | (Branch & Zero);
    seq_pc_s   = ins_pc_r + 32'd4;
    target_s   = redirect_target(seq_pc_s, ins_r, Jump);
  end

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    req_s    = req_r;
    ins_s    = ins_r;
    ins_pc_s = ins_pc_r;
    valid_s  = valid_r;
`ifdef IFU_PREFETCH_EN
    buf_s       = buf_r;
    buf_valid_s = buf_valid_r;
    tgt_s       = tgt_r;
`endif
    case (state_r)
      IDLE: begin
        state_s = REQ;
        req_s   = 1'b1;
      end
      REQ: begin
        if (imem_ack) begin
          ins_s    = imem_rdata;
          ins_pc_s = addr_r;
          valid_s  = 1'b1;
          state_s  = HOLD;
`ifdef IFU_PREFETCH_EN
          req_s    = 1'b1;
          addr_s   = addr_r + 32'd4;
`else
          req_s    = 1'b0;
`endif
        end else begin
          state_s = REQ;
        end
      end
`ifdef IFU_PREFETCH_EN
      // In HOLD exactly one of req_r (prefetch in flight) and buf_valid_r is set.
      HOLD: begin
        if (accept_s && redirect_s) begin
          buf_valid_s = 1'b0;
          valid_s     = 1'b0;
          if (req_r && !imem_ack) begin
            tgt_s   = target_s;
            state_s = DROP;
          end else begin
            req_s   = 1'b1;
            addr_s  = target_s;
            state_s = REQ;
          end
        end else if (accept_s && buf_valid_r) begin
          ins_s       = buf_r;
          ins_pc_s    = seq_pc_s;
          buf_valid_s = 1'b0;
          req_s       = 1'b1;
          addr_s      = seq_pc_s + 32'd4;
          state_s     = HOLD;
        end else if (accept_s && req_r && imem_ack) begin
          ins_s    = imem_rdata;
          ins_pc_s = addr_r;
          addr_s   = addr_r + 32'd4;
          state_s  = HOLD;
        end else if (accept_s) begin
          valid_s = 1'b0;
          state_s = REQ;
        end else if (req_r && imem_ack) begin
          buf_s       = imem_rdata;
          buf_valid_s = 1'b1;
          req_s       = 1'b0;
          state_s     = HOLD;
        end else begin
          state_s = HOLD;
        end
      end
      DROP: begin
        if (imem_ack) begin
          addr_s  = tgt_r;
          state_s = REQ;
        end else begin
          state_s = DROP;
        end
      end
`else
      HOLD: begin
        if (accept_s) begin
          valid_s = 1'b0;
          req_s   = 1'b1;
          addr_s  = redirect_s ? target_s : seq_pc_s;
          state_s = REQ;
        end else begin
          state_s = HOLD;
        end
      end
      DROP: begin
        req_s   = 1'b0;
        state_s = IDLE;
      end
`endif
      default: begin
        req_s   = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      addr_r      <= RESET_PC;
      req_r       <= 1'b0;
      ins_r       <= 32'h0000_0000;
      ins_pc_r    <= RESET_PC;
      valid_r     <= 1'b0;
`ifdef IFU_PREFETCH_EN
      buf_r       <= 32'h0000_0000;
      buf_valid_r <= 1'b0;
      tgt_r       <= RESET_PC;
`endif
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      req_r       <= req_s;
      ins_r       <= ins_s;
      ins_pc_r    <= ins_pc_s;
      valid_r     <= valid_s;
`ifdef IFU_PREFETCH_EN
      buf_r       <= buf_s;
      buf_valid_r <= buf_valid_s;
      tgt_r       <= tgt_s;
`endif
    end
  end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: scoreboard bench for ifu; expected accepts and fetch addresses are queued, monitors pop and compare.
// The IFU_PREFETCH_EN sections exercise the prefetch build when that macro is defined.
`timescale 1ns/1ps
module tb_ifu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack, ins_valid, ins_ready, Branch, Jump, Zero;
  logic [31:0] imem_addr, imem_rdata, ins, ins_pc;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_fetch_q[$];
  logic [63:0] exp_ins_q[$];
  int          mem_lat = 1;
  bit          stall_on = 1'b0;
  bit          fetch_chk = 1'b0;
  bit          watch_3008 = 1'b0;
  bit          seen_3008 = 1'b0;
  int          acc_idx = 0;
  int          acc_lim = 0;
  // per-accept downstream behaviour: cycles to stall, then {Jump,Branch,Zero}
  int          ctl_wait [19] = '{0, 2, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic [2:0]  ctl_jbz  [19] = '{3'b000, 3'b100, 3'b100, 3'b011, 3'b111, 3'b100, 3'b010,
                                 3'b001, 3'b011, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000,
                                 3'b000, 3'b000, 3'b000, 3'b000, 3'b100};

  ifu #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ins(ins), .ins_pc(ins_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .Branch(Branch), .Jump(Jump), .Zero(Zero)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_3000: return 32'h2008_0005;
      32'h0000_3004: return 32'h0800_0C10;
      32'h0000_3008: return 32'h1000_FFFE;
      32'h0000_300C: return 32'h0123_4567;
      32'h0000_3010: return 32'h1000_F3FB;
      32'h0000_3040: return 32'h0800_0C02;
      32'h0000_0000: return 32'h1000_FFFE;
      32'hFFFF_FFFC: return 32'h89AB_CDEF;
      default:       return ~a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_ins(input logic [31:0] pc);
    exp_ins_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic exp_fetch(input logic [31:0] pc);
    exp_fetch_q.push_back(pc);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_ins_q.size() != 0 || exp_fetch_q.size() != 0) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, 32'(exp_ins_q.size() + exp_fetch_q.size()), 32'd0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  // Memory model: ack after mem_lat waiting cycles; keeps acking through reset and the cycle after.
  initial begin : mem_resp
    int cnt;
    bit prev_rst;
    cnt = 0;
    prev_rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst || prev_rst) begin
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; cnt = 0;
      end else if (imem_req && !(stall_on && imem_addr == 32'h4) && cnt >= mem_lat) begin
        imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); cnt = 0;
      end else if (imem_req) begin
        imem_ack = 1'b0; cnt++;
      end else begin
        imem_ack = 1'b0; cnt = 0;
      end
      prev_rst = rst;
    end
  end

  // Downstream consumer: stalls and toggles junk controls, then accepts with the table's controls.
  initial begin : downstream
    int held;
    held = 0;
    ins_ready = 1'b0; Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !ins_valid) begin
        ins_ready = 1'b1; {Jump, Branch, Zero} = 3'b111; held = 0;
      end else if (acc_idx < acc_lim && held < ctl_wait[acc_idx]) begin
        ins_ready = 1'b0; {Jump, Branch, Zero} = 3'($urandom_range(7, 0)); held++;
      end else if (acc_idx < acc_lim) begin
        ins_ready = 1'b1; {Jump, Branch, Zero} = ctl_jbz[acc_idx]; acc_idx++; held = 0;
      end else begin
        ins_ready = 1'b0; {Jump, Branch, Zero} = 3'b111;
      end
    end
  end

  initial begin : acc_mon
    logic [63:0] e;
    forever begin
      @(negedge clk); #1;
      if (watch_3008 && ins_valid && ins_pc == 32'h3008) seen_3008 = 1'b1;
      if (!rst && ins_valid && ins_ready) begin
        if (exp_ins_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL accept_unexpected: got pc %h ins %h expected no accept", ins_pc, ins);
        end else begin
          e = exp_ins_q.pop_front();
          chk("accept_pc", ins_pc, e[63:32]);
          chk("accept_ins", ins, e[31:0]);
        end
      end
    end
  end

  initial begin : fetch_mon
    logic [31:0] e;
    forever begin
      @(negedge clk); #1;
      if (fetch_chk && !rst && imem_req && imem_ack) begin
        if (exp_fetch_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
        end else begin
          e = exp_fetch_q.pop_front();
          chk("fetch_addr", imem_addr, e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] seq [12] = '{32'h3000, 32'h3004, 32'h3040, 32'h3008, 32'h3004, 32'h3040,
                              32'h3008, 32'h300C, 32'h3010, 32'h0, 32'hFFFF_FFFC, 32'h0};
    int n;
`ifdef IFU_PREFETCH_EN
    fetch_chk = 1'b0;
`else
    fetch_chk = 1'b1;
`endif
    foreach (seq[i]) begin
      exp_ins(seq[i]);
      if (fetch_chk) exp_fetch(seq[i]);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins", ins, 32'h0);
    chk("rst_ins_pc", ins_pc, 32'h3000);
    chk("rst_imem_addr", imem_addr, 32'h3000);
    acc_lim = 12;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("idle_req_low", 32'(imem_req), 32'd0);
    @(negedge clk); #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h3000);
    @(negedge clk); #1;
    chk("wait_req_stable", 32'(imem_req), 32'd1);
    chk("wait_addr_stable", imem_addr, 32'h3000);
    chk("ack_cycle_not_valid", 32'(ins_valid), 32'd0);
    @(negedge clk); #1;
    chk("lat_valid", 32'(ins_valid), 32'd1);
    chk("lat_ins", ins, 32'h2008_0005);
    chk("lat_ins_pc", ins_pc, 32'h3000);

    n = 0;
    while (acc_idx != 12 && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("main_accepts_issued", 32'(acc_idx), 32'd12);
    stall_on = 1'b1;
    n = 0;
    while (!(imem_req && imem_addr == 32'h4) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    cycles(3);
    chk("stall_req", 32'(imem_req), 32'd1);
    chk("stall_addr", imem_addr, 32'h4);
    chk("stall_valid", 32'(ins_valid), 32'd0);
    chk("main_drained", 32'(exp_ins_q.size() + exp_fetch_q.size()), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(ins_valid), 32'd0);
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_ins_pc", ins_pc, 32'h3000);
    chk("midrst_addr", imem_addr, 32'h3000);
    stall_on = 1'b0;
    exp_ins(32'h3000);
    if (fetch_chk) begin
      exp_fetch(32'h3000);
      exp_fetch(32'h3004);
    end
    acc_lim = 13;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_drain("restart_drain");
    cycles(10);
    chk("restart_ins_pc", ins_pc, 32'h3004);
    chk("restart_valid", 32'(ins_valid), 32'd1);
    chk("restart_req_idle", 32'(imem_req), 32'd0);

`ifdef IFU_PREFETCH_EN
    // zero-bubble sequential stream with single-cycle memory
    rst = 1'b1;
    mem_lat = 0;
    fetch_chk = 1'b1;
    for (int i = 0; i < 6; i++) exp_fetch(32'h3000 + 32'(4 * i));
    for (int i = 0; i < 4; i++) exp_ins(32'h3000 + 32'(4 * i));
    acc_lim = 17;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (!ins_valid && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      chk("pf_no_bubble", 32'(ins_valid), 32'd1);
      @(negedge clk); #1;
    end
    wait_drain("pf_seq_drain");
    cycles(5);
    chk("pf_seq_last_pc", ins_pc, 32'h3010);

    // jump while the prefetch of 32'h3008 is still outstanding
    rst = 1'b1;
    mem_lat = 1;
    exp_fetch(32'h3000); exp_fetch(32'h3004); exp_fetch(32'h3008);
    exp_fetch(32'h3040); exp_fetch(32'h3044);
    exp_ins(32'h3000); exp_ins(32'h3004);
    acc_lim = 19;
    watch_3008 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_drain("pf_jump_drain");
    cycles(5);
    chk("pf_jump_pc", ins_pc, 32'h3040);
    chk("pf_jump_ins", ins, 32'h0800_0C02);
    chk("pf_jump_valid", 32'(ins_valid), 32'd1);
    chk("pf_dropped_word_seen", 32'(seen_3008), 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
